// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiply op-codes and the sequential multiplier state encoding.
package alu_pkg;

    localparam logic [5:0] OP_MULT  = 6'd24;
    localparam logic [5:0] OP_MULTU = 6'd25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulState_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add step of the radix-2 multiplier: conditional add into the upper half, then shift right.
module mult_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] accNext
);

    logic [WIDTH:0] sum;

    // The carry out of the add becomes the new MSB after the shift.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) sum = sum + {1'b0, multiplicand};
        accNext = {sum, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH-step shift-add multiplier (MULTU always; MULT when SEQ_MULTIPLIER_SIGNED_EN is defined).
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         op,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mulState_t state, nextState;

    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc, accNext;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] result;
    logic               opOk, accept, lastStep;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic isSigned, negate;

    // Signed operands run through the unsigned datapath as magnitudes.
    always_comb begin
        isSigned = (op == OP_MULT);
        opOk     = (op == OP_MULTU) || isSigned;
        magA     = (isSigned && data_a[WIDTH-1]) ? -data_a : data_a;
        magB     = (isSigned && data_b[WIDTH-1]) ? -data_b : data_b;
        result   = negate ? -accNext : accNext;
    end
`else
    always_comb begin
        opOk   = (op == OP_MULTU);
        magA   = data_a;
        magB   = data_b;
        result = accNext;
    end
`endif

    assign accept   = start && opOk && (state != RUN);
    assign lastStep = (state == RUN) && (count == CNT_W'(WIDTH-1));

    mult_step #(.WIDTH(WIDTH)) step (
        .acc          (acc),
        .multiplicand (multiplicand),
        .accNext      (accNext)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) nextState = RUN;
            RUN: begin
                busy = 1'b1;
                if (lastStep) nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = accept ? RUN : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // product only ever loads the finished result, never the running accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            acc          <= '0;
            multiplicand <= '0;
            product      <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            negate       <= 1'b0;
`endif
        end else if (accept) begin
            count        <= '0;
            acc          <= {{WIDTH{1'b0}}, magB};
            multiplicand <= magA;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            negate       <= isSigned && (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
`endif
        end else if (state == RUN) begin
            acc   <= accNext;
            count <= count + CNT_W'(1);
            if (lastStep) product <= result;
        end
    end

endmodule
